// File: rtl/mem_rd_dma.sv
// Read DMA: fetches a contiguous block over AXI read and streams it out.
// Optional perf counters with MEM_RD_DMA_PERF_EN (perf_beats, perf_stall).
//
// Ports:
//   mem_clk, mem_rst         clock, synchronous active-high reset
//   start/src_addr/num_beats job request (sampled in IDLE)
//   busy/done/err            job status; err is sticky per job
//   buf_prog_full            downstream almost-full, gates AR issue
//   ar*, r*                  AXI read address / data channels
//   m_t*                     AXI-stream output to accel_buffer
//   perf_beats, perf_stall   (MEM_RD_DMA_PERF_EN only) saturating counters

module mem_rd_dma #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 24
) (
    input  logic              mem_clk,
    input  logic              mem_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [LEN_W-1:0]  num_beats,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              buf_prog_full,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready
`ifdef MEM_RD_DMA_PERF_EN
    ,
    output logic [31:0]       perf_beats,
    output logic [31:0]       perf_stall
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

    state_t            state;
    logic [LEN_W-1:0]  rem;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] addr_step;
    logic [8:0]        len_new;
    logic [8:0]        len_cur;
    logic              beat;

    // Beats in the next burst: limited by remaining count, MAX_BURST and
    // the distance to the next 4 KB page (AXI bursts may not cross it).
    function automatic logic [8:0] burst_len(input logic [ADDR_W-1:0] a,
                                             input logic [LEN_W-1:0]  n);
        logic [31:0] to4k;
        logic [31:0] cnt;
        logic [31:0] lim;
        to4k = 32'((13'h1000 - {1'b0, a[11:0]}) >> SZ);
        cnt  = 32'(n);
        lim  = 32'(MAX_BURST);
        if (cnt < lim)
            lim = cnt;
        if (to4k < lim)
            lim = to4k;
        return lim[8:0];
    endfunction

    assign addr_in   = src_addr & ~ADDR_W'(BYTES - 1);
    assign len_new   = burst_len(addr_in, num_beats);
    assign len_cur   = burst_len(araddr, rem);
    assign addr_step = ADDR_W'({1'b0, arlen} + 9'd1) << SZ;

    assign arsize  = 3'(SZ);
    assign arburst = 2'b01;

    // R channel is a zero-latency pass-through while in DATA.
    assign beat     = (state == DATA) && rvalid && m_tready;
    assign rready   = (state == DATA) && m_tready;
    assign m_tvalid = (state == DATA) && rvalid;
    assign m_tdata  = rdata;
    assign m_tlast  = (state == DATA) && (rem == LEN_W'(1));

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            rem     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        araddr <= addr_in;
                        rem    <= num_beats;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        if (num_beats == '0) begin
                            state <= FIN;
                        end else begin
                            state <= ADDR;
                            if (!buf_prog_full) begin
                                arvalid <= 1'b1;
                                arlen   <= 8'(len_new - 9'd1);
                            end
                        end
                    end
                end
                ADDR: begin
                    // Once raised, arvalid holds until accepted.
                    if (!arvalid) begin
                        if (!buf_prog_full) begin
                            arvalid <= 1'b1;
                            arlen   <= 8'(len_cur - 9'd1);
                        end
                    end else if (arready) begin
                        arvalid <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        rem <= rem - LEN_W'(1);
                        if (rresp != 2'b00)
                            err <= 1'b1;
                        if (rlast) begin
                            if (rem == LEN_W'(1)) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                araddr <= araddr + addr_step;
                                state  <= ADDR;
                            end
                        end
                    end
                end
                FIN: begin
                    // Entered with done already set after data; a zero-beat
                    // job arrives with done low and raises it here first.
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_RD_DMA_PERF_EN
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else if (state == IDLE && start) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            if (beat && !(&perf_beats))
                perf_beats <= perf_beats + 32'd1;
            if (busy && !beat && !(&perf_stall))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_rd_dma.sv
// Bench for mem_rd_dma: random AXI slave + stream sink, reference burst
// and data model, directed 4 KB / backpressure / error / reset scenarios.

module tb_mem_rd_dma;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 16;
    localparam int LEN_W     = 24;

    logic              clk = 1'b0;
    logic              mem_rst;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [LEN_W-1:0]  num_beats;
    logic              busy, done, err;
    logic              buf_prog_full;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast, m_tvalid, m_tready;
`ifdef MEM_RD_DMA_PERF_EN
    logic [31:0]       perf_beats, perf_stall;
`endif

    always #5 clk = ~clk;

    mem_rd_dma #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)
    ) dut (
        .mem_clk(clk), .mem_rst(mem_rst),
        .start(start), .src_addr(src_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .err(err),
        .buf_prog_full(buf_prog_full),
        .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready)
`ifdef MEM_RD_DMA_PERF_EN
        , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] memf(input logic [31:0] a);
        return {a ^ 32'hA5A5_0F0F, a + 32'h0000_1357};
    endfunction

    // slave / monitor state
    int unsigned r_left = 0, gap = 0, beat_idx = 0;
    int unsigned bad_idx = 32'hFFFF_FFFF;
    int unsigned ready_pct = 100, max_gap = 0;
    logic        r_taken = 1'b0, ar_hold = 1'b0;
    logic [31:0] s_addr = '0;
    logic [31:0] b_addr[$];
    int          b_len[$];
    logic [63:0] s_data[$];
    logic        s_last[$];
    int          cyc = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
    int          start_cyc = 0;
    logic [31:0] exp_addr;
    int          exp_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always begin
        @(posedge clk);
        #1;
        arready  = ar_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        m_tready = ($urandom_range(0, 99) < ready_pct);
        if (r_taken) begin
            rvalid  = 1'b0;
            r_taken = 1'b0;
        end
        if (r_left > 0 && !rvalid) begin
            if (gap > 0) begin
                gap--;
            end else begin
                rvalid = 1'b1;
                rdata  = memf(s_addr);
                rlast  = (r_left == 1);
                rresp  = (beat_idx == bad_idx) ? 2'b10 : 2'b00;
            end
        end
        #1;
        if (mem_rst) begin
            r_left  = 0;
            rvalid  = 1'b0;
            r_taken = 1'b0;
        end else begin
            if (r_left == 0)
                check("rready_idle", 64'(rready), 64'd0);
            if (arvalid && arready) begin
                b_addr.push_back(araddr);
                b_len.push_back(int'(arlen));
                check("arsize", 64'(arsize), 64'd3);
                check("arburst", 64'(arburst), 64'd1);
                s_addr = araddr;
                r_left = int'(arlen) + 1;
                gap    = $urandom_range(0, max_gap);
            end
            if (rvalid) begin
                check("tvalid_pass", 64'(m_tvalid), 64'd1);
                check("rready_mirror", 64'(rready), 64'(m_tready));
                check("tdata_pass", m_tdata, rdata);
            end else begin
                check("tvalid_idle", 64'(m_tvalid), 64'd0);
            end
            if (m_tvalid && m_tready) begin
                s_data.push_back(m_tdata);
                s_last.push_back(m_tlast);
                if (m_tlast)
                    last_cyc = cyc;
            end
            if (rvalid && rready) begin
                r_left--;
                s_addr += 32'd8;
                beat_idx++;
                r_taken = 1'b1;
                gap     = $urandom_range(0, max_gap);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic launch(input logic [31:0] a, input int n,
                          input int unsigned bad);
        b_addr.delete();
        b_len.delete();
        s_data.delete();
        s_last.delete();
        done_cnt  = 0;
        beat_idx  = 0;
        bad_idx   = bad;
        exp_addr  = a & ~32'h7;
        exp_n     = n;
        src_addr  = a;
        num_beats = LEN_W'(n);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        check("busy_n1", 64'(busy), 64'd1);
        check("err_clear", 64'(err), 64'd0);
        check("arvalid_n1", 64'(arvalid), 64'(n != 0 && !buf_prog_full));
    endtask

    task automatic finish_job();
        logic [31:0] a;
        int          left, l, k, to4k;
        for (int i = 0; i < 5000 && done_cnt == 0; i++)
            tick();
        if (done_cnt == 0)
            check("done_timeout", 64'd0, 64'd1);
        check("busy_drop", 64'(busy), 64'd0);
        check("err_job", 64'(err), 64'(bad_idx < 32'(exp_n)));
        tick();
        tick();
        check("done_once", 64'(done_cnt), 64'd1);
        if (exp_n == 0)
            check("zero_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        else
            check("done_lat", 64'(done_cyc - last_cyc), 64'd1);
        a    = exp_addr;
        left = exp_n;
        k    = 0;
        while (left > 0) begin
            to4k = (4096 - int'(a % 4096)) / 8;
            l    = left;
            if (l > MAX_BURST) l = MAX_BURST;
            if (l > to4k) l = to4k;
            if (k < b_addr.size()) begin
                check("burst_addr", 64'(b_addr[k]), 64'(a));
                check("burst_len", 64'(b_len[k]), 64'(l - 1));
            end
            a    = a + 32'(l * 8);
            left = left - l;
            k++;
        end
        check("burst_count", 64'(b_addr.size()), 64'(k));
        check("beat_count", 64'(s_data.size()), 64'(exp_n));
        for (int i = 0; i < s_data.size() && i < exp_n; i++) begin
            check("beat_data", s_data[i], memf(exp_addr + 32'(i * 8)));
            check("beat_last", 64'(s_last[i]), 64'(i == exp_n - 1));
        end
`ifdef MEM_RD_DMA_PERF_EN
        check("perf_beats", 64'(perf_beats), 64'(exp_n));
`endif
    endtask

    initial begin
        mem_rst = 1'b1;
        start = 1'b0;
        src_addr = '0;
        num_beats = '0;
        buf_prog_full = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = '0;
        rresp = 2'b00;
        rlast = 1'b0;
        m_tready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("rst_arlen", 64'(arlen), 64'd0);
        mem_rst = 1'b0;
        tick();

        launch(32'h1000, 40, 32'hFFFF_FFFF);
        finish_job();
        if (b_addr.size() == 3) begin
            check("t1_len0", 64'(b_len[0]), 64'd15);
            check("t1_addr1", 64'(b_addr[1]), 64'h1080);
            check("t1_addr2", 64'(b_addr[2]), 64'h1100);
            check("t1_len2", 64'(b_len[2]), 64'd7);
        end

        launch(32'h0FE0, 10, 32'hFFFF_FFFF);
        finish_job();
        if (b_addr.size() == 2) begin
            check("t2_len0", 64'(b_len[0]), 64'd3);
            check("t2_addr1", 64'(b_addr[1]), 64'h1000);
            check("t2_len1", 64'(b_len[1]), 64'd5);
        end

        ar_hold = 1'b1;
        buf_prog_full = 1'b1;
        tick();
        launch(32'h2000, 20, 32'hFFFF_FFFF);
        repeat (20) begin
            tick();
            check("pf_block", 64'(arvalid), 64'd0);
        end
        buf_prog_full = 1'b0;
        tick();
        check("pf_release", 64'(arvalid), 64'd1);
        buf_prog_full = 1'b1;
        repeat (3) tick();
        check("arvalid_hold", 64'(arvalid), 64'd1);
        check("araddr_hold", 64'(araddr), 64'h2000);
        check("arlen_hold", 64'(arlen), 64'd15);
        buf_prog_full = 1'b0;
        ar_hold = 1'b0;
        finish_job();

        max_gap = 5;
        for (int j = 0; j < 6; j++) begin
            logic [31:0] a;
            ready_pct = $urandom_range(30, 100);
            a = (32'($urandom_range(1, 15)) << 12)
                - (32'($urandom_range(0, 60)) << 3)
                + 32'($urandom_range(0, 7));
            launch(a, $urandom_range(1, 70), 32'hFFFF_FFFF);
            finish_job();
        end

        launch(32'h3000, 8, 2);
        finish_job();
        check("err_after_done", 64'(err), 64'd1);

        launch(32'h4000, 0, 32'hFFFF_FFFF);
        finish_job();

        ready_pct = 100;
        max_gap = 0;
        launch(32'h5000, 40, 32'hFFFF_FFFF);
        for (int i = 0; i < 500 && s_data.size() < 5; i++)
            tick();
        check("mid_beats", 64'(s_data.size() >= 5), 64'd1);
        mem_rst = 1'b1;
        tick();
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_arvalid", 64'(arvalid), 64'd0);
        check("mrst_rready", 64'(rready), 64'd0);
        check("mrst_tvalid", 64'(m_tvalid), 64'd0);
        check("mrst_tlast", 64'(m_tlast), 64'd0);
        check("mrst_araddr", 64'(araddr), 64'd0);
        mem_rst = 1'b0;
        tick();
        launch(32'h6000, 12, 32'hFFFF_FFFF);
        finish_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
